// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the VGA pattern generator.
// Contains the mode encodings, the 3:3:2 RGB field widths and the line/frame total helpers.
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_t;

  localparam int R_W = 3;
  localparam int G_W = 3;
  localparam int B_W = 2;

  function automatic int h_total(input int display, input int front, input int sync, input int back);
    return display + front + sync + back;
  endfunction

  function automatic int v_total(input int display, input int front, input int sync, input int back);
    return display + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA timing core: pixel-tick divider, x/y raster counters, raw sync and visible flags,
// and the end-of-frame strobe used to latch per-frame controls.
module vga_timing
  import vga_pattern_pkg::*;
#(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter int XW        = $clog2(h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK)),
  parameter int YW        = $clog2(v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK))
) (
  input  logic          clk,
  input  logic          reset,
  output logic          tick,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          visible,
  output logic          frame_end,
  output logic          frame_first
);

  localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;
  logic          x_last;
  logic          y_last;

  // With CLK_DIV=1 the divider sits at zero and the tick is permanently high.
  assign tick   = (div == DW'(CLK_DIV - 1));
  assign x_last = (x == XW'(H_TOTAL - 1));
  assign y_last = (y == YW'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (tick) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign hsync_n     = !((x >= XW'(H_DISPLAY + H_FRONT)) && (x < XW'(H_DISPLAY + H_FRONT + H_SYNC)));
  assign vsync_n     = !((y >= YW'(V_DISPLAY + V_FRONT)) && (y < YW'(V_DISPLAY + V_FRONT + V_SYNC)));
  assign visible     = (x < XW'(H_DISPLAY)) && (y < YW'(V_DISPLAY));
  assign frame_end   = tick && x_last && y_last;
  assign frame_first = (x == '0) && (y == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source with frame-latched mode/colour and registered, sync-aligned outputs.
// Define VGA_PATTERN_BORDER_EN to force a white one-pixel border around the visible area.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 2,
  parameter int CHECK_LOG2 = 5,
  parameter int GRAD_SHIFT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic [1:0] mode,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_start
);

  localparam int XW    = $clog2(h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK));
  localparam int YW    = $clog2(v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK));
  localparam int BAR_W = (H_DISPLAY >= 8) ? H_DISPLAY / 8 : 1;

  logic          tick;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          hsync_n;
  logic          vsync_n;
  logic          visible;
  logic          frame_end;
  logic          frame_first;
  mode_t         shadow_mode;
  logic [7:0]    shadow_sw;
  logic [XW-1:0] bar_full;
  logic [2:0]    bar_k;
  logic          check_odd;
  logic [7:0]    pixel;

  vga_timing #(
    .H_DISPLAY (H_DISPLAY),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_DISPLAY (V_DISPLAY),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .CLK_DIV   (CLK_DIV),
    .XW        (XW),
    .YW        (YW)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .x           (x),
    .y           (y),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .visible     (visible),
    .frame_end   (frame_end),
    .frame_first (frame_first)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_mode <= MODE_SOLID;
      shadow_sw   <= '0;
    end else if (frame_end) begin
      shadow_mode <= mode_t'(mode);
      shadow_sw   <= sw;
    end
  end

  // Bar code counts down from 7 so the leftmost bar is white and the rightmost black.
  always_comb begin
    bar_full  = x / XW'(BAR_W);
    bar_k     = (bar_full > XW'(7)) ? 3'd0 : 3'd7 - bar_full[2:0];
    check_odd = 1'((x >> CHECK_LOG2) ^ XW'(y >> CHECK_LOG2));
    pixel     = shadow_sw;
    case (shadow_mode)
      MODE_SOLID: pixel = shadow_sw;
      MODE_BARS:  pixel = {{R_W{bar_k[2]}}, {G_W{bar_k[1]}}, {B_W{bar_k[0]}}};
      MODE_CHECK: pixel = check_odd ? ~shadow_sw : shadow_sw;
      MODE_GRAD:  pixel = x[7+GRAD_SHIFT:GRAD_SHIFT];
      default:    pixel = shadow_sw;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if ((x == '0) || (x == XW'(H_DISPLAY - 1)) || (y == '0) || (y == YW'(V_DISPLAY - 1))) begin
      pixel = 8'hFF;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && frame_first;
      if (tick) begin
        hsync <= hsync_n;
        vsync <= vsync_n;
        rgb   <= visible ? pixel : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on reduced timing: a pixel-index reference model
// queues the expected outputs per clk while an independent monitor pops and compares them.
module tb_vga_pattern_gen;

  localparam int HD = 160, HF = 8, HS = 16, HB = 16;
  localparam int VD = 12,  VF = 1, VS = 2,  VB = 1;
  localparam int CLK_DIV = 2, CL = 3, GS = 0;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * CLK_DIV;

  logic       clk;
  logic       reset;
  logic [7:0] sw;
  logic [1:0] mode;
  logic       hsync;
  logic       vsync;
  logic [7:0] rgb;
  logic       frame_start;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [10:0] expQ[$];
  int          cyc;
  logic [1:0]  shMode;
  logic [7:0]  shSw;
  logic [10:0] lastExp;
  int          modelFrames = 0;
  int          dutFrames   = 0;

  vga_pattern_gen #(
    .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .CLK_DIV (CLK_DIV), .CHECK_LOG2 (CL), .GRAD_SHIFT (GS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw          (sw),
    .mode        (mode),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [10:0] got, input logic [10:0] want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s: got hs=%b vs=%b fs=%b rgb=%h, expected hs=%b vs=%b fs=%b rgb=%h (t=%0t)",
                  name, got[10], got[9], got[8], got[7:0], want[10], want[9], want[8], want[7:0], $time);
  endtask

  task automatic checkMeasure(input string name, input int got, input int want);
    checkCount++;
    if (got == want) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
  endtask

  // Colour bars listed left to right straight from the bar description.
  function automatic logic [7:0] barColour(input int b);
    case (b)
      0: return 8'hFF;
      1: return 8'hFC;
      2: return 8'hE3;
      3: return 8'hE0;
      4: return 8'h1F;
      5: return 8'h1C;
      6: return 8'h03;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [10:0] modelPixel(input int x, input int y);
    logic       hs, vs, fs;
    logic [7:0] c;
    bit         vis;
    hs  = !(x >= HD + HF && x < HD + HF + HS);
    vs  = !(y >= VD + VF && y < VD + VF + VS);
    vis = (x < HD) && (y < VD);
    fs  = (x == 0) && (y == 0);
    case (shMode)
      2'd0:    c = shSw;
      2'd1:    c = barColour(x / (HD / 8));
      2'd2:    c = ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? ~shSw : shSw;
      default: c = 8'((x >> GS) & 255);
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if (x == 0 || x == HD - 1 || y == 0 || y == VD - 1) c = 8'hFF;
`endif
    if (!vis) c = 8'h00;
    return {hs, vs, fs, c};
  endfunction

  task automatic modelReset();
    cyc     = 0;
    shMode  = 2'd0;
    shSw    = 8'h00;
    lastExp = {1'b1, 1'b1, 1'b0, 8'h00};
  endtask

  // Called at a negedge: predicts the outputs after the coming posedge.
  task automatic stepCycle();
    logic [10:0] e;
    int p, x, y;
    e = lastExp;
    e[8] = 1'b0;
    if ((cyc % CLK_DIV) == CLK_DIV - 1) begin
      p = cyc / CLK_DIV;
      x = p % HT;
      y = (p / HT) % VT;
      e = modelPixel(x, y);
      if (e[8]) modelFrames++;
      if (x == HT - 1 && y == VT - 1) begin
        shMode = mode;
        shSw   = sw;
      end
    end
    cyc++;
    lastExp = e;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] s, input int n);
    mode = m;
    sw   = s;
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic runUntil(input int xt, input int yt);
    int guard;
    int p;
    guard = 0;
    p = cyc / CLK_DIV;
    while (!((p % HT) == xt && ((p / HT) % VT) == yt) && guard < 2 * FRAME_CLK) begin
      stepCycle();
      guard++;
      p = cyc / CLK_DIV;
    end
    if (guard >= 2 * FRAME_CLK) checkMeasure("run_until_bound", guard, 0);
  endtask

  initial begin : monitor
    logic [10:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pixel", {hsync, vsync, frame_start, rgb}, e);
      end
    end
  end

  initial begin : measure
    int   hsLow, vsLow, lastFall, now;
    logic prevHs, prevVs;
    hsLow = 0; vsLow = 0; lastFall = -1; now = 0; prevHs = 1'b1; prevVs = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      now++;
      if (reset) begin
        hsLow = 0; vsLow = 0; lastFall = -1; prevHs = 1'b1; prevVs = 1'b1;
      end else begin
        if (frame_start) dutFrames++;
        if (!hsync) hsLow++;
        if (!vsync) vsLow++;
        if (prevHs && !hsync) begin
          if (lastFall >= 0) checkMeasure("hsync_period", now - lastFall, HT * CLK_DIV);
          lastFall = now;
        end
        if (!prevHs && hsync) begin
          checkMeasure("hsync_low_width", hsLow, HS * CLK_DIV);
          hsLow = 0;
        end
        if (!prevVs && vsync) begin
          checkMeasure("vsync_low_width", vsLow, VS * HT * CLK_DIV);
          vsLow = 0;
        end
        prevHs = hsync;
        prevVs = vsync;
      end
    end
  end

  initial begin : driver
    reset = 1'b0;
    mode  = 2'd0;
    sw    = 8'hA5;
    modelReset();
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_values", {hsync, vsync, frame_start, rgb}, {1'b1, 1'b1, 1'b0, 8'h00});
    reset = 1'b0;
    modelReset();

    // Solid colour held from reset: frame 1 shows shadow 0, frame 2 shows A5.
    applyStimulus(2'd0, 8'hA5, 2 * FRAME_CLK);
    applyStimulus(2'd1, 8'h5A, FRAME_CLK * 3 / 2);

    // Mid-frame switch to gradient must wait for the next frame boundary.
    applyStimulus(2'd0, 8'h3C, 0);
    runUntil(0, 6);
    applyStimulus(2'd3, 8'h3C, FRAME_CLK + 1000);

    for (int i = 0; i < FRAME_CLK * 3 / 2; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        mode = 2'($urandom_range(0, 3));
        sw   = 8'($urandom);
      end
      stepCycle();
    end

    applyStimulus(2'd2, 8'hC3, 0);
    runUntil(100, 6);
    reset = 1'b1;
    #1;
    checkOutput("reset_async", {hsync, vsync, frame_start, rgb}, {1'b1, 1'b1, 1'b0, 8'h00});
    repeat (4) @(negedge clk);
    reset = 1'b0;
    modelReset();
    applyStimulus(2'd2, 8'hC3, FRAME_CLK + 2000);

    @(posedge clk);
    #2;
    checkMeasure("queue_drained", expQ.size(), 0);
    checkMeasure("frame_start_count", dutFrames, modelFrames);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
